rf_writeback: RTL and testbench

RF_WRITEBACK -- requirements
Module: rf_writeback

---
 rtl/rf_writeback_if.sv | 27 ++
 rtl/rf_writeback.sv | 85 ++++++++
 tb/tb_rf_writeback.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/rf_writeback_if.sv
// rf_writeback_if: ALU/LSU result inputs, decode pending-check ports and register-file write port
interface rf_writeback_if #(parameter int DEPTH = 4);
    localparam int CW = $clog2(DEPTH) + 1;
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_wd;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [4:0]    lsu_rd;
    logic [31:0]   lsu_wd;
    logic [4:0]    ra1;
    logic [4:0]    ra2;
    logic          pend1;
    logic          pend2;
    logic          we;
    logic [4:0]    wa;
    logic [31:0]   wd;
    logic [CW-1:0] count;
    modport master (
        output alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd, ra1, ra2,
        input  lsu_ready, pend1, pend2, we, wa, wd, count
    );
    modport slave (
        input  alu_valid, alu_rd, alu_wd, lsu_valid, lsu_rd, lsu_wd, ra1, ra2,
        output lsu_ready, pend1, pend2, we, wa, wd, count
    );
endinterface

// File: rtl/rf_writeback.sv
// rf_writeback: arbitrates ALU and queued LSU results onto one registered register-file write port
module rf_writeback #(parameter int DEPTH = 4) (
    input  logic           clk,
    input  logic           rst_n,
    rf_writeback_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [4:0]    rd_q [DEPTH];
    logic [4:0]    rd_d [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [31:0]   dat_d [DEPTH];
    logic          we_q, we_d;
    logic [4:0]    wa_q, wa_d;
    logic [31:0]   wd_q, wd_d;
    logic          acc_nz, empty, pop, byp, push, p1, p2;

    assign bus.lsu_ready = (count_q < CW'(DEPTH)) && rst_n;
    assign bus.we        = we_q;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.count     = count_q;
    assign bus.pend1     = p1 && rst_n && (bus.ra1 != 5'd0);
    assign bus.pend2     = p2 && rst_n && (bus.ra2 != 5'd0);

    always_comb begin
        p1 = 1'b0;
        p2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            p1 = p1 | (vld_q[i] && rd_q[i] == bus.ra1);
            p2 = p2 | (vld_q[i] && rd_q[i] == bus.ra2);
        end
    end

    // rd=0 LSU results are handshaken but dropped; ALU always owns the slot when valid
    always_comb begin
        acc_nz  = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != 5'd0);
        empty   = count_q == '0;
        pop     = !bus.alu_valid && !empty;
        byp     = !bus.alu_valid && empty && acc_nz;
        push    = acc_nz && !byp;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
        count_d = count_q + CW'(push) - CW'(pop);
        vld_d   = vld_q;
        rd_d    = rd_q;
        dat_d   = dat_q;
        we_d    = bus.alu_valid ? (bus.alu_rd != 5'd0) : (pop || byp);
        wa_d    = !we_d ? wa_q : bus.alu_valid ? bus.alu_rd : pop ? rd_q[rptr_q] : bus.lsu_rd;
        wd_d    = !we_d ? wd_q : bus.alu_valid ? bus.alu_wd : pop ? dat_q[rptr_q] : bus.lsu_wd;
        if (pop)
            vld_d[rptr_q] = 1'b0;
        if (push) begin
            vld_d[wptr_q] = 1'b1;
            rd_d[wptr_q]  = bus.lsu_rd;
            dat_d[wptr_q] = bus.lsu_wd;
        end
    end

    always_ff @(posedge clk) begin
        rd_q  <= rd_d;
        dat_q <= dat_d;
        if (!rst_n) begin
            count_q <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            vld_q   <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            vld_q   <= vld_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end
endmodule

// File: tb/tb_rf_writeback.sv
// tb_rf_writeback: directed vectors with hand-computed expectations for rf_writeback
module tb_rf_writeback;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    rf_writeback_if #(.DEPTH(4)) bus ();
    rf_writeback #(.DEPTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k, r, c;
        logic acc, av;
        logic [4:0] ar;
        logic [31:0] aw;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_wd = 0;
        bus.lsu_valid = 0; bus.lsu_rd = 0; bus.lsu_wd = 0;
        bus.ra1 = 0; bus.ra2 = 0;
        tick(); tick();
        chk("rst_we", bus.we, 0);
        chk("rst_wa", bus.wa, 0);
        chk("rst_wd", bus.wd, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_ready", bus.lsu_ready, 0);
        bus.ra1 = 5; bus.ra2 = 5;
        chk("rst_pend1", bus.pend1, 0);
        chk("rst_pend2", bus.pend2, 0);

        // bypass
        rst_n = 1;
        bus.lsu_valid = 1; bus.lsu_rd = 5; bus.lsu_wd = 32'hDEADBEEF;
        #1 chk("byp_ready", bus.lsu_ready, 1);
        tick();
        bus.lsu_valid = 0;
        chk("byp_we", bus.we, 1);
        chk("byp_wa", bus.wa, 5);
        chk("byp_wd", bus.wd, 32'hDEADBEEF);
        chk("byp_count", bus.count, 0);
        tick();
        chk("idle_we", bus.we, 0);
        chk("idle_wa_hold", bus.wa, 5);
        chk("idle_wd_hold", bus.wd, 32'hDEADBEEF);

        // contention: ALU owns 6 cycles, LSU fills the queue then stalls
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.alu_valid = 1; bus.alu_rd = 5'(i + 1); bus.alu_wd = 32'h100 + i;
            bus.lsu_valid = 1; bus.lsu_rd = 5'(10 + k); bus.lsu_wd = 32'h200 + k;
            #1 chk("cont_ready", bus.lsu_ready, (i < 4) ? 1 : 0);
            acc = bus.lsu_ready;
            tick();
            if (acc) k++;
            chk("cont_alu_we", bus.we, 1);
            chk("cont_alu_wa", bus.wa, i + 1);
            chk("cont_alu_wd", bus.wd, 32'h100 + i);
        end
        chk("cont_full", bus.count, 4);
        bus.alu_valid = 0;
        for (int j = 0; j < 6; j++) begin
            bus.lsu_valid = (k < 6); bus.lsu_rd = 5'(10 + k); bus.lsu_wd = 32'h200 + k;
            #1;
            if (j < 2) chk("drain_ready", bus.lsu_ready, (j == 0) ? 0 : 1);
            acc = bus.lsu_valid && bus.lsu_ready;
            tick();
            if (acc) k++;
            chk("drain_we", bus.we, 1);
            chk("drain_wa", bus.wa, 10 + j);
            chk("drain_wd", bus.wd, 32'h200 + j);
        end
        bus.lsu_valid = 0;
        chk("drain_count", bus.count, 0);
        tick();
        chk("drain_idle_we", bus.we, 0);

        // register zero
        bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_wd = 32'h55;
        bus.lsu_valid = 1; bus.lsu_rd = 0; bus.lsu_wd = 32'h66;
        #1 chk("r0_ready", bus.lsu_ready, 1);
        tick();
        chk("r0_alu_we", bus.we, 0);
        chk("r0_count", bus.count, 0);
        bus.alu_valid = 0;
        tick();
        bus.lsu_valid = 0;
        chk("r0_lsu_we", bus.we, 0);
        chk("r0_count2", bus.count, 0);
        chk("r0_wa_hold", bus.wa, 15);

        // pending check
        bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_wd = 32'h33;
        bus.lsu_valid = 1; bus.lsu_rd = 7; bus.lsu_wd = 32'h77;
        bus.ra1 = 7; bus.ra2 = 0;
        #1 chk("pend1_before", bus.pend1, 0);
        tick();
        bus.lsu_valid = 0; bus.alu_rd = 4; bus.alu_wd = 32'h44;
        chk("pend_alu_wa", bus.wa, 3);
        chk("pend_count", bus.count, 1);
        chk("pend1_hit", bus.pend1, 1);
        chk("pend2_zero", bus.pend2, 0);
        tick();
        bus.alu_valid = 0;
        chk("pend_alu_wa2", bus.wa, 4);
        chk("pend1_held", bus.pend1, 1);
        tick();
        chk("pend_pop_wa", bus.wa, 7);
        chk("pend_pop_wd", bus.wd, 32'h77);
        chk("pend1_after", bus.pend1, 0);

        // wrap-around: 12 LSU results interleaved with ALU bursts
        k = 0; r = 0; c = 0;
        while (r < 12 && c < 200) begin
            av = (c % 5) < 2; ar = 5'(1 + c % 8); aw = 32'h4000 + c;
            bus.alu_valid = av; bus.alu_rd = ar; bus.alu_wd = aw;
            bus.lsu_valid = (k < 12); bus.lsu_rd = 5'(1 + k); bus.lsu_wd = 32'h3000 + k;
            #1 acc = bus.lsu_valid && bus.lsu_ready;
            tick();
            if (acc) k++;
            if (av) begin
                chk("wrap_alu_wa", bus.wa, ar);
                chk("wrap_alu_wd", bus.wd, aw);
            end else if (bus.we && bus.wd[15:12] == 4'h3) begin
                chk("wrap_order", bus.wd, 32'h3000 + r);
                chk("wrap_rd", bus.wa, 1 + r);
                r++;
            end
            chk("wrap_le_depth", bus.count <= 4, 1);
            c++;
        end
        chk("wrap_retired", r, 12);
        bus.lsu_valid = 0; bus.alu_valid = 0;
        tick();

        // reset mid-drain
        bus.alu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_rd = 2; bus.alu_wd = i;
            bus.lsu_valid = 1; bus.lsu_rd = 5'(20 + i); bus.lsu_wd = 32'h900 + i;
            tick();
        end
        bus.lsu_valid = 0;
        chk("mid_count3", bus.count, 3);
        bus.alu_valid = 0;
        rst_n = 0;
        #1 chk("mid_ready_rst", bus.lsu_ready, 0);
        bus.ra1 = 20;
        chk("mid_pend_rst", bus.pend1, 0);
        tick();
        chk("mid_we", bus.we, 0);
        chk("mid_count0", bus.count, 0);
        chk("mid_wa", bus.wa, 0);
        rst_n = 1;
        #1 chk("mid_ready_after", bus.lsu_ready, 1);
        chk("mid_pend_after", bus.pend1, 0);
        tick();
        chk("mid_no_write", bus.we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
